// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and sizing constants for the byte-wide SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT
  } state_e;

  localparam int unsigned DIV_W      = 8;
  localparam int unsigned PHASE_W    = 5;
  localparam int unsigned LAST_PHASE = 16;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Core-side request/status bus of the SPI master.
interface spi_master_ctrl_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              cs_hold;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;

  modport master (
    output start, tx_data, cs_hold,
    input  rx_data, busy, done
  );

  modport slave (
    input  start, tx_data, cs_hold,
    output rx_data, busy, done
  );

endinterface

// File: rtl/spi_master_ctrl_phase_timer.sv
// SCLK half-period divider: ticks on the last of CLK_DIV counts, restarts on clear.
module spi_phase_timer
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0, MSB-first SPI master: one byte per accepted start, busy/done status,
// optional chip-select hold for multi-byte frames. All pins come straight from flops.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_ctrl_if.slave   bus,
  output logic               spi_clk,
  output logic               spi_mosi,
  output logic               spi_cs_n,
  input  logic               spi_miso
);

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [DATA_W-2:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                cs_n_q, cs_n_d;
  logic                accept;
  logic                tick;

  assign accept = bus.start && !busy_q;

  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    unique case (state_q)
      IDLE: begin
        // CS release is deferred to IDLE so a start in the done cycle keeps the frame open.
        if (accept) begin
          state_d = SETUP;
          phase_d = '0;
          tx_sh_d = bus.tx_data[DATA_W-2:0];
          rx_sh_d = '0;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = bus.tx_data[DATA_W-1];
        end else if (!bus.cs_hold) begin
          cs_n_d = 1'b1;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso};
          state_d = SHIFT;
          phase_d = PHASE_W'(1);
        end
      end
      SHIFT: begin
        if (tick) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == PHASE_W'(LAST_PHASE)) begin
            rx_data_d = rx_sh_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
            phase_d   = '0;
          end else if (phase_q[0]) begin
            sclk_d = 1'b0;
            // After the last sample MOSI keeps bit 0 through the CS hold phase.
            if (phase_q != PHASE_W'(LAST_PHASE - 1)) begin
              mosi_d  = tx_sh_q[DATA_W-2];
              tx_sh_d = {tx_sh_q[DATA_W-3:0], 1'b0};
            end
          end else begin
            sclk_d  = 1'b1;
            rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign spi_clk     = sclk_q;
  assign spi_mosi    = mosi_q;
  assign spi_cs_n    = cs_n_q;

endmodule
